// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared channel state type and constants for the UART baud generator
package uart_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } chan_state_e;

  localparam int UART_MIN_DIV    = 2;
  localparam int UART_FRAME_BITS = 10;
  localparam int UART_IDX_W      = 4;

endpackage

// File: rtl/uart_baud_chan.sv
// rtl/uart_baud_chan.sv - one bit-timing channel: FSM, bit counter, strobes (fraction under UART_BAUD_FRAC_EN)
module uart_baud_chan
  import uart_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 4,
  parameter int FRAME_BITS = UART_FRAME_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIV_W-1:0]      div_i,
  input  logic [FRAC_W-1:0]     frac_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  sample_o,
  output logic                  tick_o,
  output logic [UART_IDX_W-1:0] bit_idx_o,
  output logic                  done_o
);

  localparam logic [DIV_W:0]      CNT_ONE  = (DIV_W+1)'(1);
  localparam logic [UART_IDX_W-1:0] IDX_ONE  = UART_IDX_W'(1);
  localparam logic [UART_IDX_W-1:0] IDX_LAST = UART_IDX_W'(FRAME_BITS - 1);

  chan_state_e           state_q, state_d;
  logic [DIV_W:0]        cnt_q, cnt_d;
  logic [DIV_W:0]        per_q, per_d;
  logic [UART_IDX_W-1:0] idx_q, idx_d;
  logic                  sample_q, sample_d;
  logic                  tick_q, tick_d;
  logic                  done_q, done_d;
  logic [DIV_W:0]        per_next;
  logic                  bit_end;
  logic                  last_bit;

  assign bit_end  = (state_q == ST_RUN) && (cnt_q == (per_q - CNT_ONE));
  assign last_bit = (idx_q == IDX_LAST);

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W:0]   acc_sum;

  // The accumulator carry stretches the next bit by one cycle
  assign acc_sum  = {1'b0, acc_q} + {1'b0, frac_i};
  assign per_next = {1'b0, div_i} + {{DIV_W{1'b0}}, acc_sum[FRAC_W]};
`else
  logic unused_frac;

  assign unused_frac = ^frac_i;
  assign per_next    = {1'b0, div_i};
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: start always (re)enters RUN; abort or the final tick returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (start_i)                    state_d = ST_RUN;
        else if (abort_i)               state_d = ST_IDLE;
        else if (bit_end && last_bit)   state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counters and strobe compares; the period only changes at a bit boundary or a start
  always_comb begin
    cnt_d    = cnt_q;
    per_d    = per_q;
    idx_d    = idx_q;
    sample_d = 1'b0;
    tick_d   = 1'b0;
    done_d   = 1'b0;
`ifdef UART_BAUD_FRAC_EN
    acc_d    = acc_q;
`endif
    if (start_i) begin
      cnt_d = '0;
      idx_d = '0;
      per_d = {1'b0, div_i};
`ifdef UART_BAUD_FRAC_EN
      acc_d = '0;
`endif
    end else if (state_q == ST_RUN) begin
      if (abort_i) begin
        cnt_d = '0;
        idx_d = '0;
      end else begin
        sample_d = (cnt_q == (per_q >> 1));
        tick_d   = bit_end;
        done_d   = bit_end && last_bit;
        if (bit_end) begin
          cnt_d = '0;
          idx_d = last_bit ? '0 : idx_q + IDX_ONE;
          per_d = per_next;
`ifdef UART_BAUD_FRAC_EN
          acc_d = acc_sum[FRAC_W-1:0];
`endif
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    end
  end

  // Datapath and registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      per_q    <= (DIV_W+1)'(UART_MIN_DIV);
      idx_q    <= '0;
      sample_q <= 1'b0;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_BAUD_FRAC_EN
      acc_q    <= '0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      idx_q    <= idx_d;
      sample_q <= sample_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
`ifdef UART_BAUD_FRAC_EN
      acc_q    <= acc_d;
`endif
    end
  end

  // The FSM leaves RUN on the edge that launches the final tick, so done keeps busy
  // high through that tick's cycle
  assign busy_o    = (state_q == ST_RUN) || done_q;
  assign sample_o  = sample_q;
  assign tick_o    = tick_q;
  assign done_o    = done_q;
  assign bit_idx_o = idx_q;

endmodule

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - multi-channel UART bit-timing generator with shared divisor shadow (fraction under UART_BAUD_FRAC_EN)
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 4,
  parameter int FRAME_BITS = UART_FRAME_BITS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DIV_W-1:0]          div_int,
  input  logic [FRAC_W-1:0]         div_frac,
  input  logic                      div_load,
  input  logic [NCH-1:0]            start,
  input  logic [NCH-1:0]            abort,
  output logic [NCH-1:0]            busy,
  output logic [NCH-1:0]            sample,
  output logic [NCH-1:0]            tick,
  output logic [NCH*UART_IDX_W-1:0] bit_idx,
  output logic [NCH-1:0]            done
);

  localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(UART_MIN_DIV);

  logic [DIV_W-1:0]  div_sh_q, div_sh_d;
  logic [FRAC_W-1:0] frac_sh;

  // Divisors below two cannot fit a mid-bit and an end-of-bit compare, so clamp at load
  always_comb begin
    div_sh_d = div_sh_q;
    if (div_load) div_sh_d = (div_int < MIN_DIV) ? MIN_DIV : div_int;
  end

  // Integer divisor shadow shared by all channels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_sh_q <= MIN_DIV;
    end else begin
      div_sh_q <= div_sh_d;
    end
  end

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] frac_sh_q;

  // Fractional divisor shadow, loaded together with the integer part
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frac_sh_q <= '0;
    end else if (div_load) begin
      frac_sh_q <= div_frac;
    end
  end

  assign frac_sh = frac_sh_q;
`else
  assign frac_sh = div_frac;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    uart_baud_chan #(
      .DIV_W      (DIV_W),
      .FRAC_W     (FRAC_W),
      .FRAME_BITS (FRAME_BITS)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .div_i     (div_sh_q),
      .frac_i    (frac_sh),
      .start_i   (start[i]),
      .abort_i   (abort[i]),
      .busy_o    (busy[i]),
      .sample_o  (sample[i]),
      .tick_o    (tick[i]),
      .bit_idx_o (bit_idx[i*UART_IDX_W +: UART_IDX_W]),
      .done_o    (done[i])
    );
  end

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb/tb_uart_baud_gen.sv - scoreboard bench for uart_baud_gen (default and UART_BAUD_FRAC_EN builds)
module tb_uart_baud_gen;

  localparam int NCH    = 2;
  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DIV_W-1:0]  div_int = '0;
  logic [FRAC_W-1:0] div_frac = '0;
  logic              div_load = 1'b0;
  logic [NCH-1:0]    start = '0;
  logic [NCH-1:0]    abort = '0;
  logic [NCH-1:0]    busy;
  logic [NCH-1:0]    sample;
  logic [NCH-1:0]    tick;
  logic [NCH*4-1:0]  bit_idx;
  logic [NCH-1:0]    done;

  uart_baud_gen #(.NCH(NCH), .DIV_W(DIV_W), .FRAC_W(FRAC_W), .FRAME_BITS(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .div_int  (div_int),
    .div_frac (div_frac),
    .div_load (div_load),
    .start    (start),
    .abort    (abort),
    .busy     (busy),
    .sample   (sample),
    .tick     (tick),
    .bit_idx  (bit_idx),
    .done     (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int ch;
    int kind;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  per_tab[10];

  function automatic string kname(int k);
    case (k)
      0:       return "sample";
      1:       return "tick";
      default: return "done";
    endcase
  endfunction

  // Monitor: every strobe must match an expected event for this cycle; overdue events are misses
  always @(negedge clk) begin
    logic [2:0] obs;
    int hit;
    for (int ch = 0; ch < NCH; ch++) begin
      obs = {done[ch], tick[ch], sample[ch]};
      for (int k = 0; k < 3; k++) begin
        if (obs[k]) begin
          hit = -1;
          for (int j = 0; j < exp_q.size(); j++)
            if (hit < 0 && exp_q[j].ch == ch && exp_q[j].kind == k && exp_q[j].cyc == cyc) hit = j;
          checks++;
          if (hit >= 0) begin
            exp_q.delete(hit);
          end else begin
            errors++;
            $display("FAIL unexpected_%s ch%0d cycle %0d: actual 1 required 0", kname(k), ch, cyc);
          end
        end
      end
    end
    for (int j = exp_q.size() - 1; j >= 0; j--) begin
      if (exp_q[j].cyc <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_%s ch%0d cycle %0d: actual 0 required 1", kname(exp_q[j].kind),
                 exp_q[j].ch, exp_q[j].cyc);
        exp_q.delete(j);
      end
    end
  end

  task automatic chk(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(int c);
    while (cyc < c) step();
  endtask

  task automatic load_div(int d, int f);
    div_int  = DIV_W'(d);
    div_frac = FRAC_W'(f);
    div_load = 1'b1;
    step();
    div_load = 1'b0;
  endtask

  task automatic fire(logic [NCH-1:0] s, logic [NCH-1:0] a);
    start = s;
    abort = a;
    step();
    start = '0;
    abort = '0;
  endtask

  task automatic set_per(int first, int rest);
    per_tab[0] = first;
    for (int b = 1; b < 10; b++) per_tab[b] = rest;
  endtask

  // Model of one frame started in cycle t0: cnt is 0 in t0+1, each bit lasts per_tab[b]
  task automatic push_frame(int ch, int t0);
    int t;
    ev_t e;
    t = t0 + 1;
    for (int b = 0; b < 10; b++) begin
      e.ch = ch;
      e.kind = 0; e.cyc = t + per_tab[b] / 2 + 1; exp_q.push_back(e);
      e.kind = 1; e.cyc = t + per_tab[b];         exp_q.push_back(e);
      t = t + per_tab[b];
    end
    e.ch = ch; e.kind = 2; e.cyc = t;
    exp_q.push_back(e);
  endtask

  task automatic cancel(int ch, int from);
    for (int j = exp_q.size() - 1; j >= 0; j--)
      if (exp_q[j].ch == ch && exp_q[j].cyc >= from) exp_q.delete(j);
  endtask

  task automatic drain(string name, int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: actual %0d events pending required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1);
  end

  initial begin
    int t0;
    int t1;
    int bad;
    int fin;

    // Reset state and quiet idle
    repeat (3) step();
    chk("reset_busy", int'(busy), 0);
    chk("reset_sample", int'(sample), 0);
    chk("reset_tick", int'(tick), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_bit_idx", int'(bit_idx), 0);
    rst_n = 1'b1;
    step();
    bad = 0;
    repeat (1000) begin
      step();
      if (busy != '0 || bit_idx != '0) bad++;
    end
    chk("idle_quiet", bad, 0);

    // Basic timing, D = 217 on ch0
    load_div(217, 0);
    t0 = cyc;
    set_per(217, 217);
    push_frame(0, t0);
    fire(2'b01, 2'b00);
    chk("basic_busy_c1", int'(busy[0]), 1);
    chk("basic_idx_c1", int'(bit_idx[3:0]), 0);
    wait_cyc(t0 + 218);
    chk("basic_idx_after_tick1", int'(bit_idx[3:0]), 1);
    wait_cyc(t0 + 2171);
    chk("basic_busy_final_tick", int'(busy[0]), 1);
    wait_cyc(t0 + 2172);
    chk("basic_busy_after", int'(busy[0]), 0);
    drain("basic", 100);

    // Abort ch1 at cycle 300 while ch0 runs on
    load_div(100, 0);
    t0 = cyc;
    set_per(100, 100);
    push_frame(0, t0);
    push_frame(1, t0);
    fire(2'b11, 2'b00);
    wait_cyc(t0 + 300);
    cancel(1, t0 + 301);
    abort = 2'b10;
    step();
    abort = '0;
    chk("abort_busy1", int'(busy[1]), 0);
    chk("abort_busy0", int'(busy[0]), 1);
    drain("abort", 1200);
    chk("abort_all_idle", int'(busy), 0);

    // Start and abort together restart the frame
    t0 = cyc;
    push_frame(0, t0);
    fire(2'b01, 2'b00);
    wait_cyc(t0 + 250);
    chk("restart_idx_before", int'(bit_idx[3:0]), 2);
    t1 = cyc;
    cancel(0, t1 + 1);
    push_frame(0, t1);
    fire(2'b01, 2'b01);
    chk("restart_busy", int'(busy[0]), 1);
    chk("restart_idx", int'(bit_idx[3:0]), 0);
    wait_cyc(t1 + 330);
    cancel(0, cyc + 1);
    fire(2'b00, 2'b01);
    chk("restart_abort_busy", int'(busy[0]), 0);
    drain("restart", 50);

    // Divisor change mid-bit, then clamp of div_int=1
    t0 = cyc;
    set_per(100, 50);
    push_frame(0, t0);
    fire(2'b01, 2'b00);
    wait_cyc(t0 + 40);
    load_div(50, 0);
    drain("divchg", 700);
    step();
    chk("divchg_idle", int'(busy[0]), 0);
    load_div(1, 0);
    t0 = cyc;
    set_per(2, 2);
    push_frame(0, t0);
    fire(2'b01, 2'b00);
    drain("clamp", 100);
    chk("clamp_idle", int'(busy[0]), 0);

    // Fractional divisor on ch1
    load_div(217, 8);
    t0 = cyc;
`ifdef UART_BAUD_FRAC_EN
    per_tab = '{217, 217, 218, 217, 218, 217, 218, 217, 218, 217};
    fin = t0 + 2175;
`else
    set_per(217, 217);
    fin = t0 + 2171;
`endif
    push_frame(1, t0);
    fire(2'b10, 2'b00);
    wait_cyc(fin);
    chk("frac_busy_final", int'(busy[1]), 1);
    wait_cyc(fin + 1);
    chk("frac_busy_after", int'(busy[1]), 0);
    drain("frac", 50);

    // Reset mid-frame at bit 4
    load_div(100, 0);
    t0 = cyc;
    set_per(100, 100);
    push_frame(0, t0);
    fire(2'b01, 2'b00);
    wait_cyc(t0 + 450);
    chk("rstmid_idx_before", int'(bit_idx[3:0]), 4);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_bit_idx", int'(bit_idx), 0);
    chk("rstmid_strobes", int'({sample, tick, done}), 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    load_div(100, 0);
    t0 = cyc;
    push_frame(0, t0);
    fire(2'b01, 2'b00);
    wait_cyc(t0 + 101);
    chk("rstmid_first_tick", int'(tick[0]), 1);
    drain("rstmid", 1100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
